// File: rtl/rv_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: opcodes, FSM states, trap causes, WB mux select.
package rv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [31:0] INSN_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT, TRAP} state_t;
   typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_MISALIGN, CAUSE_BUS} trap_cause_t;
   typedef enum logic [1:0] {WB_ALU, WB_LMD, WB_PC4} wb_sel_t;

   function automatic logic is_legal_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
         OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv_wait_timer.sv
// Bus wait counter: counts cycles spent waiting for ready; expired once MEM_TIMEOUT waits have elapsed.
module rv_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(MEM_TIMEOUT + 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == W'(MEM_TIMEOUT));

   // Saturates at the limit so a stalled owner cannot wrap back into range.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !expired_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/rv_multicycle_sequencer.sv
// Multi-cycle RV32I control path: owns PC/IR and sequences FETCH/DECODE/EXECUTE/MEM/WB around the datapath,
// with handshake memories, bus timeout, illegal/misaligned traps, halt at instruction boundaries and a retire counter.
module rv_multicycle_sequencer
   import rv_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              MEM_TIMEOUT = 15,
   parameter int              CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic [31:0]      imem_rdata,
   input  logic             imem_ready,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   input  logic             ex_branch_flag,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             halt_req,
   output logic [XLEN-1:0]  pc,
   output logic [31:0]      ir,
   output logic             ex_en,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic [CNT_W-1:0] retired,
   output logic             halted,
   output logic             trap,
   output logic [1:0]       trap_cause
);
   state_t           state_q;
   trap_cause_t      cause_q;
   logic [XLEN-1:0]  pc_q, tgt_q, pc_plus4;
   logic [31:0]      ir_q;
   logic [CNT_W-1:0] retired_q;
   logic [6:0]       opcode;
   logic             is_jump, misalign, wait_st, ready_now, tmr_expired;
   state_t           boundary_st;
   wb_sel_t          wb_sel_c;

   assign opcode      = ir_q[6:0];
   assign pc_plus4    = pc_q + XLEN'(4);
   assign is_jump     = (opcode == OPC_JAL) || (opcode == OPC_JALR);
   assign misalign    = (ex_target[1:0] != 2'b00);
   assign boundary_st = halt_req ? HALT : FETCH;
   assign wait_st     = (state_q == FETCH) || (state_q == MEM);
   assign ready_now   = (state_q == FETCH) ? imem_ready : dmem_ready;

   rv_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk       (clk),
      .reset_i   (reset),
      .clr_i     (!wait_st || ready_now),
      .en_i      (wait_st && !ready_now),
      .expired_o (tmr_expired)
   );

   always_comb begin
      wb_sel_c = WB_ALU;
      if (opcode == OPC_LOAD)
         wb_sel_c = WB_LMD;
      else if (is_jump)
         wb_sel_c = WB_PC4;
   end

   assign imem_req   = (state_q == FETCH);
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == MEM);
   assign dmem_we    = (state_q == MEM) && (opcode == OPC_STORE);
   assign pc         = pc_q;
   assign ir         = ir_q;
   assign ex_en      = (state_q == EXECUTE);
   assign rf_we      = (state_q == WB);
   assign wb_sel     = wb_sel_c;
   assign retired    = retired_q;
   assign halted     = (state_q == HALT);
   assign trap       = (state_q == TRAP);
   assign trap_cause = cause_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         cause_q   <= CAUSE_NONE;
         pc_q      <= RESET_PC;
         tgt_q     <= '0;
         ir_q      <= INSN_NOP;
         retired_q <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ready) begin
                  ir_q    <= imem_rdata;
                  state_q <= DECODE;
               end else if (tmr_expired) begin
                  cause_q <= CAUSE_BUS;
                  state_q <= TRAP;
               end
            end
            DECODE: begin
               if (is_legal_opcode(opcode)) begin
                  state_q <= EXECUTE;
               end else begin
                  cause_q <= CAUSE_ILLEGAL;
                  state_q <= TRAP;
               end
            end
            EXECUTE: begin
               tgt_q <= ex_target;
               if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
                  state_q <= MEM;
               end else if (opcode == OPC_BRANCH) begin
                  if (ex_branch_flag && misalign) begin
                     cause_q <= CAUSE_MISALIGN;
                     state_q <= TRAP;
                  end else begin
                     pc_q      <= ex_branch_flag ? ex_target : pc_plus4;
                     retired_q <= retired_q + CNT_W'(1);
                     state_q   <= boundary_st;
                  end
               end else if (is_jump && misalign) begin
                  cause_q <= CAUSE_MISALIGN;
                  state_q <= TRAP;
               end else begin
                  state_q <= WB;
               end
            end
            MEM: begin
               if (dmem_ready) begin
                  if (opcode == OPC_STORE) begin
                     pc_q      <= pc_plus4;
                     retired_q <= retired_q + CNT_W'(1);
                     state_q   <= boundary_st;
                  end else begin
                     state_q <= WB;
                  end
               end else if (tmr_expired) begin
                  cause_q <= CAUSE_BUS;
                  state_q <= TRAP;
               end
            end
            WB: begin
               pc_q      <= is_jump ? tgt_q : pc_plus4;
               retired_q <= retired_q + CNT_W'(1);
               state_q   <= boundary_st;
            end
            HALT: begin
               if (!halt_req)
                  state_q <= FETCH;
            end
            TRAP: state_q <= TRAP;
            default: state_q <= TRAP;
         endcase
      end
   end

endmodule
